dram_read_arbiter: RTL
======================

Name: dram_read_arbiter

Overview:
- Shares the single Avalon-MM DRAM master port between two requesters: the display scanout reader (read-only, latency-critical) and the GPU render/CPU path (read/write).
- Display has fixed priority, with a starvation guard for the GPU.
- Pipelined reads are tracked in order so that each readdatavalid is routed back to the requester that issued the read.
- Sits between the scanout DRAM master and the SDRAM controller, in the sys clock domain.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- BE_W, 4, byteenable width (DATA_W/8).
- MAX_PENDING, 8, maximum outstanding reads; power of 2, at least 2.
- STARVE_LIMIT, 16, cycles the GPU may wait before it is forced to priority.

Ports:
- clk  in  1  system clock; single clock domain.
- resetn  in  1  asynchronous, active-low reset.
- d_address  in  ADDR_W  display read address.
- d_read  in  1  display read request.
- d_waitrequest  out  1  display stall.
- d_readdata  out  DATA_W  read data (broadcast).
- d_readdatavalid  out  1  display response valid.
- g_address  in  ADDR_W  GPU address.
- g_read  in  1  GPU read request.
- g_write  in  1  GPU write request.
- g_writedata  in  DATA_W  GPU write data.
- g_byteenable  in  BE_W  GPU byte enables.
- g_waitrequest  out  1  GPU stall.
- g_readdata  out  DATA_W  read data (broadcast).
- g_readdatavalid  out  1  GPU response valid.
- m_address  out  ADDR_W  to slave.
- m_read  out  1  to slave.
- m_write  out  1  to slave.
- m_writedata  out  DATA_W  to slave.
- m_byteenable  out  BE_W  to slave; all-ones for display reads.
- m_waitrequest  in  1  slave stall.
- m_readdata  in  DATA_W  slave read data.
- m_readdatavalid  in  1  slave response valid.
- pending_count  out  log2(MAX_PENDING)+1  outstanding reads (registered).
- err_orphan  out  1  sticky flag: response received with no read outstanding.

Behaviour:
- Reset (async):
  - lock cleared, starve counter 0, owner FIFO empty, pending_count 0, err_orphan 0.
  - m_read/m_write 0; both *_readdatavalid 0; both *_waitrequest 1 unless granted.
- Read eligibility: a read request is eligible iff registered pending_count < MAX_PENDING. Writes are always eligible.
- GPU request = g_read | g_write. g_read and g_write together is illegal; the write is issued and the read ignored.
- Grant, when unlocked (combinational, zero-cycle arbitration), in priority order:
  1. GPU request eligible and starve counter == STARVE_LIMIT -> GPU.
  2. d_read eligible -> display.
  3. GPU request eligible -> GPU.
  4. Otherwise none.
- Output mux:
  - m_* are driven from the granted requester; m_read/m_write are 0 when there is no grant.
  - Granted requester's waitrequest = m_waitrequest; the non-granted requester's waitrequest = 1.
- Accept: a transfer is accepted on a cycle where it is granted, m_read|m_write = 1 and m_waitrequest = 0.
- Lock:
  - If the granted transfer sees m_waitrequest = 1, register the lock (owner bit) at the clock edge.
  - While locked, grant goes to the owner regardless of priority or starvation; clear the lock on accept.
  - Requesters hold signals per Avalon while stalled.
- Starve counter:
  - +1 each cycle a GPU request is present and not accepted, saturating at STARVE_LIMIT.
  - Cleared on GPU accept, or when there is no GPU request.
- Owner FIFO (1-bit: 0 = display, 1 = GPU):
  - Push on every accepted read.
  - Pop on m_readdatavalid; the popped bit selects which *_readdatavalid pulses, in the same cycle (combinational route).
  - *_readdata = m_readdata for both requesters.
- pending_count:
  - push only -> +1; pop only -> -1; push and pop together -> unchanged.
  - A slot freed by a pop allows a new read only on the next cycle.
- Orphan response: m_readdatavalid while the FIFO is empty -> no valid to either requester, err_orphan set to 1, sticky until reset.
- Reset mid-operation: all tracking is lost. Responses to reads issued before reset arrive as orphans and set err_orphan; software resets the slave alongside.
- Writes do not enter the FIFO and have no response phase.
- Guarantee: the display waits at most one GPU transfer per STARVE_LIMIT+1 cycles of contention (plus slave stalls).

Decomposition:
- Shared package: OWNER_DISP = 1'b0, OWNER_GPU = 1'b1; helper function clog2 for the pending_count width.
- Sub-module: owner_fifo — synchronous, 1-bit wide, depth MAX_PENDING, async active-low reset, push/pop/empty/full/count, simultaneous push+pop supported (including when full or empty with push).
- Grant, lock and starve logic stay in the top module.

Test Plan:
- Idle, single display read to 0x100, m_waitrequest = 0 -> m_read = 1 and m_address = 0x100 same cycle, d_waitrequest = 0, g_waitrequest = 1; m_readdatavalid 3 cycles later with data 0xABCD -> d_readdatavalid = 1, g_readdatavalid = 0, pending_count back to 0.
- STARVE_LIMIT = 4, both requesting continuously, m_waitrequest = 0 -> accept order D,D,D,D,G,D,D,D,D,G; starve counter clears after each G.
- Display granted, m_waitrequest = 1 for 3 cycles, GPU raises g_write during the stall -> m_address stays the display address and g_waitrequest = 1 until display accept; GPU write accepted the next cycle.
- MAX_PENDING = 8, eight display reads accepted with no responses -> 9th: m_read = 0, d_waitrequest = 1, pending_count = 8; a GPU write still passes; one response -> the read issues on the following cycle.
- Accept D, G, D reads; responses A, B, C -> d_readdatavalid pulses with A then C, g_readdatavalid with B; a simultaneous push+pop cycle leaves pending_count unchanged.
- Two reads pending, pulse resetn low -> pending_count = 0, outputs at reset values; three later m_readdatavalid pulses -> no *_readdatavalid, err_orphan = 1 and held.

Source files
------------

// File: rtl/dram_read_arbiter_pkg.sv
// Shared constants and helpers for the DRAM read arbiter.
package dram_read_arbiter_pkg;

    // Owner tag stored per outstanding read.
    localparam logic OWNER_DISP = 1'b0;
    localparam logic OWNER_GPU  = 1'b1;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dram_read_arbiter_owner_fifo.sv
// In-order owner tag FIFO: one bit per outstanding read, head visible combinationally.
module owner_fifo
    import dram_read_arbiter_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic          push_data,
    input  logic          pop,
    output logic          pop_data,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop_data = mem[rd_ptr];

    // A pop on an empty FIFO is ignored; a push into a full FIFO is accepted only if a pop frees a slot.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dram_read_arbiter.sv
// Two-port Avalon-MM arbiter: display has fixed priority, GPU gets a starvation
// guard, and read responses are routed back in issue order.
module dram_read_arbiter
    import dram_read_arbiter_pkg::*;
#(
    parameter  int ADDR_W       = 32,
    parameter  int DATA_W       = 32,
    parameter  int BE_W         = 4,
    parameter  int MAX_PENDING  = 8,
    parameter  int STARVE_LIMIT = 16,
    localparam int PC_W         = clog2(MAX_PENDING) + 1,
    localparam int SC_W         = clog2(STARVE_LIMIT + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    output logic              d_waitrequest,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_readdatavalid,
    input  logic [ADDR_W-1:0] g_address,
    input  logic              g_read,
    input  logic              g_write,
    input  logic [DATA_W-1:0] g_writedata,
    input  logic [BE_W-1:0]   g_byteenable,
    output logic              g_waitrequest,
    output logic [DATA_W-1:0] g_readdata,
    output logic              g_readdatavalid,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    output logic [BE_W-1:0]   m_byteenable,
    input  logic              m_waitrequest,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid,
    output logic [PC_W-1:0]   pending_count,
    output logic              err_orphan
);

    logic            lock_q;
    logic            lock_owner_q;
    logic [SC_W-1:0] starve_q;
    logic            grant_valid;
    logic            grant_sel;
    logic            rd_ok;
    logic            g_req;
    logic            g_elig;
    logic            d_elig;
    logic            xfer;
    logic            accept;
    logic            fifo_empty;
    logic            fifo_full;
    logic            head_owner;

    // Reads are eligible only while the owner FIFO (i.e. registered pending_count) has room.
    assign rd_ok  = ~fifo_full;
    assign g_req  = g_read | g_write;
    assign g_elig = g_write | (g_read & rd_ok);
    assign d_elig = d_read & rd_ok;

    // Zero-cycle arbitration; a stalled owner keeps the port until its transfer is accepted.
    always_comb begin
        grant_valid = 1'b0;
        grant_sel   = OWNER_DISP;
        if (lock_q) begin
            grant_valid = 1'b1;
            grant_sel   = lock_owner_q;
        end else if (g_elig && (starve_q == SC_W'(STARVE_LIMIT))) begin
            grant_valid = 1'b1;
            grant_sel   = OWNER_GPU;
        end else if (d_elig) begin
            grant_valid = 1'b1;
            grant_sel   = OWNER_DISP;
        end else if (g_elig) begin
            grant_valid = 1'b1;
            grant_sel   = OWNER_GPU;
        end
    end

    // Master-side mux; a simultaneous GPU read+write issues only the write.
    always_comb begin
        m_address     = d_address;
        m_writedata   = g_writedata;
        m_byteenable  = '1;
        m_read        = 1'b0;
        m_write       = 1'b0;
        d_waitrequest = 1'b1;
        g_waitrequest = 1'b1;
        if (grant_valid) begin
            if (grant_sel == OWNER_GPU) begin
                m_address     = g_address;
                m_byteenable  = g_byteenable;
                m_write       = g_write;
                m_read        = g_read & ~g_write;
                g_waitrequest = m_waitrequest;
            end else begin
                m_read        = d_read;
                d_waitrequest = m_waitrequest;
            end
        end
    end

    assign xfer   = m_read | m_write;
    assign accept = xfer & ~m_waitrequest;

    // Lock the grant to the current owner while the slave stalls it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_q       <= 1'b0;
            lock_owner_q <= OWNER_DISP;
        end else if (accept) begin
            lock_q <= 1'b0;
        end else if (xfer && m_waitrequest) begin
            lock_q       <= 1'b1;
            lock_owner_q <= grant_sel;
        end
    end

    // Count cycles the GPU waits, saturating at the limit that forces it to priority.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_q <= '0;
        end else if (!g_req || (accept && grant_sel == OWNER_GPU)) begin
            starve_q <= '0;
        end else if (starve_q != SC_W'(STARVE_LIMIT)) begin
            starve_q <= starve_q + 1'b1;
        end
    end

    owner_fifo #(
        .DEPTH (MAX_PENDING)
    ) u_owner_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (accept & m_read),
        .push_data (grant_sel),
        .pop       (m_readdatavalid),
        .pop_data  (head_owner),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (pending_count)
    );

    assign d_readdata      = m_readdata;
    assign g_readdata      = m_readdata;
    assign d_readdatavalid = m_readdatavalid & ~fifo_empty & (head_owner == OWNER_DISP);
    assign g_readdatavalid = m_readdatavalid & ~fifo_empty & (head_owner == OWNER_GPU);

    // Sticky flag for a response that arrives with nothing outstanding.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_orphan <= 1'b0;
        end else if (m_readdatavalid && fifo_empty) begin
            err_orphan <= 1'b1;
        end
    end

endmodule
